// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   state_e       loader FSM states
//   DefaultMagic  default frame start byte
//   is_busy()     true for the states in which a load is in progress
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StMagic = 3'd1,
    StCntLo = 3'd2,
    StCntHi = 3'd3,
    StData  = 3'd4,
    StCheck = 3'd5,
    StDone  = 3'd6,
    StError = 3'd7
  } state_e;

  localparam logic [7:0] DefaultMagic = 8'hA5;

  function automatic logic is_busy(state_e s);
    return s inside {StMagic, StCntLo, StCntHi, StData, StCheck};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader.
//   in_data/in_valid/in_ready   byte stream, transfer = in_valid & in_ready
//   mem_we/mem_addr/mem_wdata   word-wide imem write port
// master: loader side; slave: stream source and memory side.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
//   clk, rst_n     clock, async active-low reset
//   clr_i          restart packing at byte 0
//   byte_valid_i   byte_i is consumed this cycle
//   byte_i         stream byte
//   word_valid_o   1-cycle pulse the cycle after the 4th byte
//   word_o         {b3,b2,b1,b0}, b0 first received; held until the next word
module imem_loader_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] sh_q, sh_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;

  always_comb begin
    idx_d        = idx_q;
    sh_d         = sh_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clr_i) begin
      idx_d = 2'd0;
      sh_d  = 24'd0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        word_d       = {byte_i, sh_q};
        word_valid_d = 1'b1;
      end else begin
        // Shift in from the top so the first byte ends up in word[7:0].
        sh_d = {byte_i, sh_q[23:8]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= 2'd0;
      sh_q         <= 24'd0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into imem.
// Frame: MAGIC, CNT_LO, CNT_HI, CNT little-endian words, CHK (XOR of all bytes after MAGIC).
//   clk, rst_n     clock, async active-low reset
//   start_i        1-cycle pulse, arms a load from idle/done/error
//   bus_io         byte stream in, imem write port out
//   busy_o         load in progress
//   done_o         last load finished with good checksum (sticky)
//   error_o        last load failed (sticky)
//   core_rst_n_o   core reset, low while busy or in error
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int unsigned DepthWords = 4096,
  parameter logic [7:0]  Magic      = DefaultMagic
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  imem_loader_if.master bus_io,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic          core_rst_n_o
);

  // Largest word count that still fits between BaseAddr and the end of imem.
  localparam int unsigned MaxWords = DepthWords - 32'(BaseAddr >> 2);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        in_ready_q, busy_q, done_q, error_q, core_rst_n_q;
  logic        xfer, pk_clr, pk_valid, pk_word_valid;
  logic [15:0] cnt_new;
  logic [31:0] pk_word;

  assign xfer    = bus_io.in_valid & in_ready_q;
  assign cnt_new = {bus_io.in_data, cnt_q[7:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    word_idx_d = word_idx_q;
    chk_d      = chk_q;
    byte_idx_d = byte_idx_q;
    pk_clr     = 1'b0;
    pk_valid   = 1'b0;

    // Address advances as each word is written, one cycle behind acceptance.
    if (pk_word_valid) word_idx_d = word_idx_q + 16'd1;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d    = StMagic;
          chk_d      = 8'd0;
          byte_idx_d = 2'd0;
          wcnt_d     = 16'd0;
          word_idx_d = 16'd0;
          pk_clr     = 1'b1;
        end
      end
      StMagic: begin
        if (xfer && bus_io.in_data == Magic) state_d = StCntLo;
      end
      StCntLo: begin
        if (xfer) begin
          cnt_d[7:0] = bus_io.in_data;
          chk_d      = chk_q ^ bus_io.in_data;
          state_d    = StCntHi;
        end
      end
      StCntHi: begin
        if (xfer) begin
          cnt_d = cnt_new;
          chk_d = chk_q ^ bus_io.in_data;
          if ({16'd0, cnt_new} > MaxWords) state_d = StError;
          else if (cnt_new == 16'd0)       state_d = StCheck;
          else                             state_d = StData;
        end
      end
      StData: begin
        if (xfer) begin
          chk_d      = chk_q ^ bus_io.in_data;
          pk_valid   = 1'b1;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wcnt_d = wcnt_q + 16'd1;
            // Leave on the last byte so the checksum byte is never packed.
            if (wcnt_q == cnt_q - 16'd1) state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (xfer) state_d = (bus_io.in_data == chk_q) ? StDone : StError;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      wcnt_q       <= 16'd0;
      word_idx_q   <= 16'd0;
      chk_q        <= 8'd0;
      byte_idx_q   <= 2'd0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      word_idx_q   <= word_idx_d;
      chk_q        <= chk_d;
      byte_idx_q   <= byte_idx_d;
      // Status outputs are registered from the next state so they track state_q exactly.
      in_ready_q   <= is_busy(state_d);
      busy_q       <= is_busy(state_d);
      done_q       <= (state_d == StDone);
      error_q      <= (state_d == StError);
      core_rst_n_q <= !(is_busy(state_d) || state_d == StError);
    end
  end

  imem_loader_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (pk_clr),
    .byte_valid_i (pk_valid),
    .byte_i       (bus_io.in_data),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word)
  );

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.mem_we    = pk_word_valid;
  assign bus_io.mem_wdata = pk_word;
  assign bus_io.mem_addr  = BaseAddr + {14'd0, word_idx_q, 2'b00};

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign core_rst_n_o = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, resync on magic, zero-word load,
// count overflow, reset mid-load, and gapped stream with ignored start pulses.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic busy, done, err, core_rst_n;

  imem_loader_if bus ();

  imem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .bus_io       (bus),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (err),
    .core_rst_n_o (core_rst_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0]  frame[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      log_addr.push_back(bus.mem_addr);
      log_data.push_back(bus.mem_wdata);
    end
  end

  // Hold a byte until it is taken; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_byte timeout on byte %h", b);
    end
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_end(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst.in_ready got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst.mem_we got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst.mem_addr got %h want 0", bus.mem_addr); end
    n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst.mem_wdata got %h want 0", bus.mem_wdata); end
    n_cmp++; if ({busy, done, err, core_rst_n} !== 4'b0001) begin
      n_bad++; $display("FAIL rst.flags got %b want 0001", {busy, done, err, core_rst_n});
    end
  endtask

  task automatic test_good_frame();
    logic ok;
    log_addr.delete(); log_data.delete();
    pulse_start();
    n_cmp++; if ({busy, done, err, core_rst_n} !== 4'b1000) begin
      n_bad++; $display("FAIL good.armed flags got %b want 1000", {busy, done, err, core_rst_n});
    end
    // Checksum: 02^00^13^00^00^00^93^00^10^00 = 92
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    send_frame();
    wait_end(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL good.end timeout got 0 want 1"); end
    n_cmp++; if ({busy, done, err, core_rst_n} !== 4'b0101) begin
      n_bad++; $display("FAIL good.flags got %b want 0101", {busy, done, err, core_rst_n});
    end
    n_cmp++; if (log_addr.size() !== 2) begin
      n_bad++; $display("FAIL good.nwrites got %0d want 2", log_addr.size());
    end else begin
      n_cmp++; if (log_addr[0] !== 32'h0 || log_data[0] !== 32'h0000_0013) begin
        n_bad++; $display("FAIL good.w0 got %h/%h want 0/00000013", log_addr[0], log_data[0]);
      end
      n_cmp++; if (log_addr[1] !== 32'h4 || log_data[1] !== 32'h0010_0093) begin
        n_bad++; $display("FAIL good.w1 got %h/%h want 4/00100093", log_addr[1], log_data[1]);
      end
    end
  endtask

  task automatic test_bad_chk();
    logic ok;
    log_addr.delete(); log_data.delete();
    pulse_start();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL badchk.done_cleared got %b want 0", done); end
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    send_frame();
    wait_end(ok);
    n_cmp++; if ({ok, busy, done, err, core_rst_n} !== 5'b10010) begin
      n_bad++; $display("FAIL badchk.flags got %b want 10010", {ok, busy, done, err, core_rst_n});
    end
    n_cmp++; if (log_data.size() !== 2) begin
      n_bad++; $display("FAIL badchk.nwrites got %0d want 2", log_data.size());
    end else begin
      n_cmp++; if (log_data[1] !== 32'h0010_0093) begin
        n_bad++; $display("FAIL badchk.w1 got %h want 00100093", log_data[1]);
      end
    end
  endtask

  task automatic test_resync_zero();
    logic ok;
    log_addr.delete(); log_data.delete();
    pulse_start();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL zero.err_cleared got %b want 0", err); end
    frame = '{8'h3C, 8'h11, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_end(ok);
    n_cmp++; if ({ok, busy, done, err, core_rst_n} !== 5'b10101) begin
      n_bad++; $display("FAIL zero.flags got %b want 10101", {ok, busy, done, err, core_rst_n});
    end
    n_cmp++; if (log_addr.size() !== 0) begin
      n_bad++; $display("FAIL zero.nwrites got %0d want 0", log_addr.size());
    end
  endtask

  task automatic test_count_overflow();
    logic ok;
    log_addr.delete(); log_data.delete();
    pulse_start();
    frame = '{8'hA5, 8'h01, 8'h10};
    send_frame();
    wait_end(ok);
    n_cmp++; if ({ok, busy, done, err, core_rst_n} !== 5'b10010) begin
      n_bad++; $display("FAIL ovf.flags got %b want 10010", {ok, busy, done, err, core_rst_n});
    end
    n_cmp++; if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL ovf.in_ready got %b want 0", bus.in_ready);
    end
    n_cmp++; if (log_addr.size() !== 0) begin
      n_bad++; $display("FAIL ovf.nwrites got %0d want 0", log_addr.size());
    end
  endtask

  task automatic test_reset_mid_load();
    logic ok;
    log_addr.delete(); log_data.delete();
    pulse_start();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_frame();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (log_addr.size() !== 0) begin
      n_bad++; $display("FAIL midrst.nwrites got %0d want 0", log_addr.size());
    end
    pulse_start();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    send_frame();
    wait_end(ok);
    n_cmp++; if ({ok, done, err} !== 3'b110) begin
      n_bad++; $display("FAIL midrst.flags got %b want 110", {ok, done, err});
    end
    n_cmp++; if (log_data.size() !== 2) begin
      n_bad++; $display("FAIL midrst.nwrites2 got %0d want 2", log_data.size());
    end else begin
      n_cmp++; if (log_data[0] !== 32'h0000_0013 || log_addr[1] !== 32'h4) begin
        n_bad++; $display("FAIL midrst.image got %h/%h want 00000013/4", log_data[0], log_addr[1]);
      end
    end
  endtask

  task automatic test_random_gaps();
    logic ok;
    logic [31:0] exp_w[3];
    exp_w = '{32'hDEAD_BEEF, 32'h0123_4567, 32'hCAFE_F00D};
    log_addr.delete(); log_data.delete();
    pulse_start();
    // Checksum: 03 ^ 00 ^ (22 ^ 00 ^ C9) = E8
    frame = '{8'hA5, 8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01,
              8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hE8};
    foreach (frame[i]) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if (i == 5 || i == 10) begin
        bus.in_valid = 1'b0;
        pulse_start();
        n_cmp++; if (busy !== 1'b1) begin
          n_bad++; $display("FAIL gaps.start_ignored[%0d] busy got %b want 1", i, busy);
        end
      end
      send_byte(frame[i]);
    end
    bus.in_valid = 1'b0;
    wait_end(ok);
    n_cmp++; if ({ok, done, err, core_rst_n} !== 4'b1101) begin
      n_bad++; $display("FAIL gaps.flags got %b want 1101", {ok, done, err, core_rst_n});
    end
    n_cmp++; if (log_addr.size() !== 3) begin
      n_bad++; $display("FAIL gaps.nwrites got %0d want 3", log_addr.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (log_addr[k] !== 32'(4 * k) || log_data[k] !== exp_w[k]) begin
          n_bad++;
          $display("FAIL gaps.w%0d got %h/%h want %h/%h", k, log_addr[k], log_data[k], 4 * k,
                   exp_w[k]);
        end
      end
    end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_resync_zero();
    test_count_overflow();
    test_reset_mid_load();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
